global_register_bank: RTL
=========================

// Module: global_register_bank
// PURPOSE
//  Downstream consumer of the command decoder's wrreg/rdreg strobes, register_address and 16-bit write data.
//  Holds the chip's global configuration registers and services WrReg writes.
//  Services RdReg reads by pushing {address,value} readback words into a small first-word-fall-through FIFO.
//  The output-frame builder drains that FIFO with a ready/valid handshake.
// PARAMETERS
//  ADDR_W      9    register address width
//  DATA_W      16   register data width
//  NUM_REGS    138  implemented registers, addresses 0..NUM_REGS-1
//  FIFO_DEPTH  8    readback FIFO entries, power of two
// PORTS
//  clk80                   in   1              system clock, all logic on rising edge
//  reset_n                 in   1              asynchronous, active-low reset
//  clear                   in   1              decoder Clear strobe: flush FIFO, clear sticky flags
//  wrreg                   in   1              decoder WrReg command strobe
//  rdreg                   in   1              decoder RdReg command strobe
//  register_address        in   ADDR_W         target address, qualified by register_address_valid
//  register_address_valid  in   1              1-cycle pulse, address complete
//  data_in                 in   DATA_W         write data, qualified by data_in_valid
//  data_in_valid           in   1              1-cycle pulse, write data complete
//  rb_ready                in   1              downstream accepts readback word
//  rb_valid                out  1              FIFO head valid
//  rb_data                 out  ADDR_W+DATA_W  {address, value} at FIFO head
//  rb_level                out  clog2(D)+1     FIFO occupancy, 0..FIFO_DEPTH
//  rb_overflow             out  1              sticky: readback dropped because FIFO was full
//  bad_addr                out  1              sticky: access to address >= NUM_REGS
// BEHAVIOUR
//  Reset (async assert, sync release): all registers, FIFO pointers and level, and every output go to 0.
//  Address latch: on register_address_valid, adx_q <= register_address.
//  Read: register_address_valid & rdreg enqueues {register_address, reg[register_address]} at the next edge.
//    rb_valid rises 1 cycle after the read pulse when the FIFO was empty.
//  Write: data_in_valid & wrreg writes reg[adx_q] <= data_in at the edge.
//    The write is visible to any read in a later cycle.
//  Same-cycle write and read to the same address forwards data_in (write-first).
//  Out-of-range address (>= NUM_REGS):
//    write is ignored; read enqueues value 0 with the original address; bad_addr is set in both cases.
//  data_in_valid without wrreg, or rdreg without register_address_valid, is ignored with no flag.
//  Pop on rb_valid & rb_ready; rb_data/rb_valid then update to the next entry 1 cycle later (FWFT).
//  Full with push and no pop: push dropped, rb_overflow set, FIFO contents unchanged.
//  Full with push and pop in the same cycle: both happen, rb_level stays FIFO_DEPTH, no overflow.
//  Empty with push and pop: no pop, since rb_valid was 0; push accepted.
//  Pointers wrap modulo FIFO_DEPTH; rb_level is a separate counter that never wraps.
//  clear: the FIFO empties at the next edge and sticky flags drop; registers and adx_q are kept.
//    clear dominates a same-cycle push.
//  reset_n low mid-transaction aborts it; a pending data_in_valid after release uses adx_q=0.
// TESTING
//  Reset, then read addr 5 -> rb_valid at +1 cycle, rb_data={9'd5,16'h0000}, rb_level=1.
//  Write 16'h817E to addr 0, read addr 0 in the next cycle -> rb_data={9'd0,16'h817E}.
//  Same-cycle write 16'hBEEF and read to addr 3 -> readback 16'hBEEF.
//  rb_ready=0, issue 9 reads -> rb_level=8, rb_overflow=1, first 8 entries intact in order.
//    Pulse clear -> rb_level=0, rb_overflow=0, register contents unchanged.
//  Write addr 200 with 16'h1234 -> bad_addr=1, no register changes.
//    Read addr 200 -> rb_data={9'd200,16'h0000}.
//  FIFO full, rb_ready=1 with a read each cycle for 20 cycles -> level held at 8, no overflow, no lost words.
//    Then assert reset_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/global_register_bank.sv
// global_register_bank
// Global configuration register file driven by the command decoder strobes.
// Writes land at the latched address adx_q; reads push {address, value}
// readback words into a small first-word-fall-through FIFO that the
// output-frame builder drains with a ready/valid handshake.
module global_register_bank #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 138,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk80,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          wrreg,
  input  logic                          rdreg,
  input  logic [ADDR_W-1:0]             register_address,
  input  logic                          register_address_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          data_in_valid,
  input  logic                          rb_ready,
  output logic                          rb_valid,
  output logic [ADDR_W+DATA_W-1:0]      rb_data,
  output logic [$clog2(FIFO_DEPTH):0]   rb_level,
  output logic                          rb_overflow,
  output logic                          bad_addr
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int RB_W  = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);

  // Register file and latched write address
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [ADDR_W-1:0] adx_q, adx_d;

  // Readback FIFO storage, pointers and occupancy
  logic [RB_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [RB_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Registered outputs
  logic              rb_valid_q, rb_valid_d;
  logic [RB_W-1:0]   rb_data_q, rb_data_d;
  logic              overflow_q, overflow_d;
  logic              bad_addr_q, bad_addr_d;

  // Decoded command qualifiers
  logic              wr_en_s;
  logic              wr_in_range_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              push_s;
  logic              rd_in_range_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [DATA_W-1:0] rd_value_s;
  logic              pop_s;
  logic              full_s;
  logic              accept_push_s;
  logic              drop_push_s;
  logic              bad_event_s;

  // Decode strobes, range checks and the write-first readback value
  always_comb begin
    wr_en_s       = wrreg & data_in_valid;
    wr_in_range_s = (adx_q < NUM_REGS_A);
    wr_idx_s      = adx_q[IDX_W-1:0];
    push_s        = rdreg & register_address_valid;
    rd_in_range_s = (register_address < NUM_REGS_A);
    rd_idx_s      = register_address[IDX_W-1:0];
    pop_s         = rb_valid_q & rb_ready;
    full_s        = (level_q == LVL_FULL);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    accept_push_s = push_s & (~full_s | pop_s);
    drop_push_s   = push_s & full_s & ~pop_s;
    bad_event_s   = (push_s & ~rd_in_range_s) | (wr_en_s & ~wr_in_range_s);
    if (!rd_in_range_s) begin
      rd_value_s = {DATA_W{1'b0}};
    end else if (wr_en_s && wr_in_range_s && (adx_q == register_address)) begin
      // Same-cycle write to the address being read: return the new data.
      rd_value_s = data_in;
    end else begin
      rd_value_s = regs_q[rd_idx_s];
    end
  end

  // Next state of the register file and the latched address
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en_s && wr_in_range_s) begin
      regs_d[wr_idx_s] = data_in;
    end else begin
      regs_d[wr_idx_s] = regs_q[wr_idx_s];
    end
    if (register_address_valid) begin
      adx_d = register_address;
    end else begin
      adx_d = adx_q;
    end
  end

  // Next state of the readback FIFO, sticky flags and output registers
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    bad_addr_d = bad_addr_q;
    if (clear) begin
      // Flush dominates any same-cycle push or pop; registers are untouched.
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      level_d    = {LVL_W{1'b0}};
      overflow_d = 1'b0;
      bad_addr_d = 1'b0;
    end else begin
      if (accept_push_s) begin
        fifo_d[wr_ptr_q] = {register_address, rd_value_s};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d         = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({accept_push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      overflow_d = overflow_q | drop_push_s;
      bad_addr_d = bad_addr_q | bad_event_s;
    end
    rb_valid_d = (level_d != {LVL_W{1'b0}});
    rb_data_d  = fifo_d[rd_ptr_d];
  end

  // Register file and address latch state
  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
      adx_q <= {ADDR_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      adx_q <= adx_d;
    end
  end

  // Readback FIFO, sticky flag and output state
  always_ff @(posedge clk80 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= {RB_W{1'b0}};
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      rb_valid_q <= 1'b0;
      rb_data_q  <= {RB_W{1'b0}};
      overflow_q <= 1'b0;
      bad_addr_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rb_valid_q <= rb_valid_d;
      rb_data_q  <= rb_data_d;
      overflow_q <= overflow_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign rb_valid    = rb_valid_q;
  assign rb_data     = rb_data_q;
  assign rb_level    = level_q;
  assign rb_overflow = overflow_q;
  assign bad_addr    = bad_addr_q;

endmodule
